// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous memory.
// Each access goes IDLE -> ISSUE (grant + memory strobe) and, for reads, -> RDATA.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RDATA = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  ptr_q, ptr_d;
    logic                  win_q, win_d;
    logic                  gnt0_q, gnt0_d;
    logic                  gnt1_q, gnt1_d;
    logic                  rvalid0_q, rvalid0_d;
    logic                  rvalid1_q, rvalid1_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
    logic                  busy_q, busy_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_wr_en_q, mem_wr_en_d;
    logic                  mem_rd_en_q, mem_rd_en_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    // Requester 1 wins when alone, or when both ask and the pointer favours it.
    logic pick1_c;
    logic sel_we_c;
    assign pick1_c  = req1 & (~req0 | ptr_q);
    assign sel_we_c = pick1_c ? we1 : we0;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        rvalid0_d   = 1'b0;
        rvalid1_d   = 1'b0;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wr_en_d = 1'b0;
        mem_rd_en_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    win_d       = pick1_c;
                    ptr_d       = ~pick1_c;
                    gnt0_d      = ~pick1_c;
                    gnt1_d      = pick1_c;
                    mem_addr_d  = pick1_c ? addr1 : addr0;
                    mem_wdata_d = pick1_c ? wdata1 : wdata0;
                    mem_wr_en_d = sel_we_c;
                    mem_rd_en_d = ~sel_we_c;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                state_d = mem_rd_en_q ? RDATA : IDLE;
            end
            RDATA: begin
                // Memory output is valid now: it sampled mem_rd_en at the end of ISSUE.
                if (win_q) begin
                    rdata1_d  = mem_rdata;
                    rvalid1_d = 1'b1;
                end else begin
                    rdata0_d  = mem_rdata;
                    rvalid0_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            win_q       <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            busy_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wr_en_q <= 1'b0;
            mem_rd_en_q <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            busy_q      <= busy_d;
            mem_addr_q  <= mem_addr_d;
            mem_wr_en_q <= mem_wr_en_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign busy      = busy_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wr_en = mem_wr_en_q;
    assign mem_rd_en = mem_rd_en_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of per-cycle vectors plus reset/abort sequences,
// with a small synchronous memory model attached to the mem_* port.
module tb_mem_arbiter;

    localparam int unsigned AW = 2;
    localparam int unsigned DW = 8;
    localparam logic I = 1'b1;
    localparam logic O = 1'b0;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1, busy;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] mem_addr;
    logic          mem_wr_en, mem_rd_en;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
        .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous memory: read data appears one cycle after mem_rd_en is sampled.
    logic [DW-1:0] mem [4];
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        logic r0, w0; logic [AW-1:0] a0; logic [DW-1:0] d0;
        logic r1, w1; logic [AW-1:0] a1; logic [DW-1:0] d1;
        logic g0, g1, v0, v1;
        logic [DW-1:0] rd0, rd1;
        logic bz;
        logic [AW-1:0] ma;
        logic wr, rd;
        logic [DW-1:0] md;
    } vec_t;

    localparam int NV = 22;
    vec_t tbl [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " gnt0"},      32'(gnt0),      32'd0);
        chk({tag, " gnt1"},      32'(gnt1),      32'd0);
        chk({tag, " rvalid0"},   32'(rvalid0),   32'd0);
        chk({tag, " rvalid1"},   32'(rvalid1),   32'd0);
        chk({tag, " rdata0"},    32'(rdata0),    32'd0);
        chk({tag, " rdata1"},    32'(rdata1),    32'd0);
        chk({tag, " busy"},      32'(busy),      32'd0);
        chk({tag, " mem_addr"},  32'(mem_addr),  32'd0);
        chk({tag, " mem_wr_en"}, 32'(mem_wr_en), 32'd0);
        chk({tag, " mem_rd_en"}, 32'(mem_rd_en), 32'd0);
        chk({tag, " mem_wdata"}, 32'(mem_wdata), 32'd0);
    endtask

    task automatic check_row(input int i, input vec_t v);
        string t;
        t = $sformatf("row%0d", i);
        chk({t, " gnt0"},      32'(gnt0),      32'(v.g0));
        chk({t, " gnt1"},      32'(gnt1),      32'(v.g1));
        chk({t, " rvalid0"},   32'(rvalid0),   32'(v.v0));
        chk({t, " rvalid1"},   32'(rvalid1),   32'(v.v1));
        chk({t, " rdata0"},    32'(rdata0),    32'(v.rd0));
        chk({t, " rdata1"},    32'(rdata1),    32'(v.rd1));
        chk({t, " busy"},      32'(busy),      32'(v.bz));
        chk({t, " mem_addr"},  32'(mem_addr),  32'(v.ma));
        chk({t, " mem_wr_en"}, 32'(mem_wr_en), 32'(v.wr));
        chk({t, " mem_rd_en"}, 32'(mem_rd_en), 32'(v.rd));
        chk({t, " mem_wdata"}, 32'(mem_wdata), 32'(v.md));
    endtask

    // Two grants in one cycle is never legal.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (gnt0 && gnt1) begin
                errors++;
                $display("FAIL dual_grant: got gnt0=%0b gnt1=%0b expected at most one", gnt0, gnt1);
            end
        end
    end

    initial begin
        // Fields: r0 w0 a0 d0 | r1 w1 a1 d1 || g0 g1 v0 v1 rd0 rd1 busy ma wr rd md
        // Single write, then read-back by requester 1.
        tbl[0]  = '{I,I,2'd2,8'hA5, O,O,2'd0,8'h00, I,O,O,O, 8'h00,8'h00, I, 2'd2, I,O, 8'hA5};
        tbl[1]  = '{O,O,2'd2,8'hA5, O,O,2'd0,8'h00, O,O,O,O, 8'h00,8'h00, O, 2'd2, O,O, 8'hA5};
        tbl[2]  = '{O,O,2'd0,8'h00, I,O,2'd2,8'h00, O,I,O,O, 8'h00,8'h00, I, 2'd2, O,I, 8'h00};
        tbl[3]  = '{O,O,2'd0,8'h00, O,O,2'd0,8'h00, O,O,O,O, 8'h00,8'h00, I, 2'd2, O,O, 8'h00};
        tbl[4]  = '{O,O,2'd0,8'h00, O,O,2'd0,8'h00, O,O,O,I, 8'h00,8'hA5, O, 2'd2, O,O, 8'h00};
        tbl[5]  = '{O,O,2'd0,8'h00, O,O,2'd0,8'h00, O,O,O,O, 8'h00,8'hA5, O, 2'd2, O,O, 8'h00};
        // Both requesters held with writes: grants alternate 0,1,0,1 starting from ptr=0.
        tbl[6]  = '{I,I,2'd0,8'h11, I,I,2'd1,8'h22, I,O,O,O, 8'h00,8'hA5, I, 2'd0, I,O, 8'h11};
        tbl[7]  = '{I,I,2'd0,8'h11, I,I,2'd1,8'h22, O,O,O,O, 8'h00,8'hA5, O, 2'd0, O,O, 8'h11};
        tbl[8]  = '{I,I,2'd0,8'h11, I,I,2'd1,8'h22, O,I,O,O, 8'h00,8'hA5, I, 2'd1, I,O, 8'h22};
        tbl[9]  = '{I,I,2'd0,8'h11, I,I,2'd1,8'h22, O,O,O,O, 8'h00,8'hA5, O, 2'd1, O,O, 8'h22};
        tbl[10] = '{I,I,2'd0,8'h11, I,I,2'd1,8'h22, I,O,O,O, 8'h00,8'hA5, I, 2'd0, I,O, 8'h11};
        tbl[11] = '{I,I,2'd0,8'h11, I,I,2'd1,8'h22, O,O,O,O, 8'h00,8'hA5, O, 2'd0, O,O, 8'h11};
        tbl[12] = '{I,I,2'd0,8'h11, I,I,2'd1,8'h22, O,I,O,O, 8'h00,8'hA5, I, 2'd1, I,O, 8'h22};
        tbl[13] = '{O,O,2'd0,8'h00, O,O,2'd0,8'h00, O,O,O,O, 8'h00,8'hA5, O, 2'd1, O,O, 8'h22};
        // Read by 0; requester 1 raises req during RDATA and is served next.
        tbl[14] = '{I,O,2'd1,8'h00, O,O,2'd0,8'h00, I,O,O,O, 8'h00,8'hA5, I, 2'd1, O,I, 8'h00};
        tbl[15] = '{O,O,2'd0,8'h00, O,O,2'd0,8'h00, O,O,O,O, 8'h00,8'hA5, I, 2'd1, O,O, 8'h00};
        tbl[16] = '{O,O,2'd0,8'h00, I,O,2'd0,8'h00, O,O,I,O, 8'h22,8'hA5, O, 2'd1, O,O, 8'h00};
        tbl[17] = '{O,O,2'd0,8'h00, I,O,2'd0,8'h00, O,I,O,O, 8'h22,8'hA5, I, 2'd0, O,I, 8'h00};
        tbl[18] = '{O,O,2'd0,8'h00, O,O,2'd0,8'h00, O,O,O,O, 8'h22,8'hA5, I, 2'd0, O,O, 8'h00};
        tbl[19] = '{O,O,2'd0,8'h00, O,O,2'd0,8'h00, O,O,O,I, 8'h22,8'h11, O, 2'd0, O,O, 8'h00};
        // Lone requester 1 wins while ptr points at 0; write leaves rdata untouched.
        tbl[20] = '{O,O,2'd0,8'h00, I,I,2'd3,8'h5A, O,I,O,O, 8'h22,8'h11, I, 2'd3, I,O, 8'h5A};
        tbl[21] = '{O,O,2'd0,8'h00, O,O,2'd0,8'h00, O,O,O,O, 8'h22,8'h11, O, 2'd3, O,O, 8'h5A};

        for (int k = 0; k < 4; k++) mem[k] = 8'h00;
        mem_rdata = 8'h00;
        drive(O, O, 2'd0, 8'h00, O, O, 2'd0, 8'h00);
        reset = 1'b0;
        #1;
        check_zero("reset_t0");
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_held");
        @(negedge clk);
        reset = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
                  tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
            @(posedge clk);
            #1;
            check_row(i, tbl[i]);
        end

        // Read by 0 aborted by reset while in RDATA.
        @(negedge clk);
        drive(I, O, 2'd2, 8'h00, O, O, 2'd0, 8'h00);
        @(posedge clk);
        #1;
        chk("abort gnt0", 32'(gnt0), 32'd1);
        @(negedge clk);
        drive(O, O, 2'd0, 8'h00, O, O, 2'd0, 8'h00);
        @(posedge clk);
        #1;
        chk("abort in_rdata busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_zero("abort_async");
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("abort post%0d rvalid0", c), 32'(rvalid0), 32'd0);
            chk($sformatf("abort post%0d busy", c),    32'(busy),    32'd0);
        end

        // Fresh read by 1 after reset completes normally.
        @(negedge clk);
        drive(O, O, 2'd0, 8'h00, I, O, 2'd3, 8'h00);
        @(posedge clk);
        #1;
        chk("fresh gnt1",      32'(gnt1),      32'd1);
        chk("fresh mem_rd_en", 32'(mem_rd_en), 32'd1);
        chk("fresh mem_addr",  32'(mem_addr),  32'd3);
        @(negedge clk);
        drive(O, O, 2'd0, 8'h00, O, O, 2'd0, 8'h00);
        @(posedge clk);
        #1;
        chk("fresh rdata_wait rvalid1", 32'(rvalid1), 32'd0);
        @(posedge clk);
        #1;
        chk("fresh rvalid1", 32'(rvalid1), 32'd1);
        chk("fresh rdata1",  32'(rdata1),  32'h5A);
        chk("fresh rdata0",  32'(rdata0),  32'd0);
        @(posedge clk);
        #1;
        chk("fresh rvalid1_off", 32'(rvalid1), 32'd0);
        chk("fresh rdata1_hold", 32'(rdata1),  32'h5A);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
